// File: rtl/seq_serial_tx.sv
// seq_serial_tx -- MSB-first serial frame transmitter with an in-line
// "11011" pattern counter.
//
// A frame is launched from IDLE by start: data is loaded into the shift
// register and len (1..32; 0 and 33..63 mean 32) bits are sent, one per
// cycle, unless hold stalls the shifter. After the last bit the block spends
// one cycle in DONE (done=1) and then returns to IDLE. While bits are sent, a
// Mealy tracker counts overlapping "11011" occurrences within the frame.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   start       frame request, sampled only in IDLE
//   data[31:0]  frame payload, bit 31 sent first
//   len[5:0]    frame length in bits
//   hold        stall; freezes the shifter while in SHIFT
//   dout        serial bit (0 outside SHIFT)
//   dout_valid  dout carries a frame bit this cycle
//   busy        frame in progress (SHIFT or DONE)
//   done        one-cycle end-of-frame pulse
//   match_cnt   "11011" count for the current or most recent frame
module seq_serial_tx (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] data,
    input  logic [5:0]  len,
    input  logic        hold,
    output logic        dout,
    output logic        dout_valid,
    output logic        busy,
    output logic        done,
    output logic [3:0]  match_cnt
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // Tracker states name the longest received suffix that is a prefix of "11011".
    typedef enum logic [2:0] {P_NONE, P_1, P_11, P_110, P_1101} pat_t;

    state_t      state, state_nxt;
    pat_t        pat, pat_nxt;
    logic        pat_hit;
    logic [31:0] sreg;
    logic [5:0]  cnt;

    function automatic logic [5:0] eff_len(input logic [5:0] l);
        return ((l == 6'd0) || (l > 6'd32)) ? 6'd32 : l;
    endfunction

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (!hold && (cnt == 6'd1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        dout       = (state == SHIFT) ? sreg[31] : 1'b0;
        dout_valid = (state == SHIFT) && !hold;
        busy       = (state == SHIFT) || (state == DONE);
        done       = (state == DONE);
    end

    // Pattern step on the bit currently presented; after a hit the trailing
    // "11" is kept so overlapping occurrences are counted.
    always_comb begin
        pat_nxt = P_NONE;
        pat_hit = 1'b0;
        case (pat)
            P_NONE:  pat_nxt = sreg[31] ? P_1 : P_NONE;
            P_1:     pat_nxt = sreg[31] ? P_11 : P_NONE;
            P_11:    pat_nxt = sreg[31] ? P_11 : P_110;
            P_110:   pat_nxt = sreg[31] ? P_1101 : P_NONE;
            P_1101: begin
                pat_nxt = sreg[31] ? P_11 : P_NONE;
                pat_hit = sreg[31];
            end
            default: pat_nxt = P_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sreg      <= '0;
            cnt       <= '0;
            pat       <= P_NONE;
            match_cnt <= '0;
        end else if ((state == IDLE) && start) begin
            sreg      <= data;
            cnt       <= eff_len(len);
            pat       <= P_NONE;
            match_cnt <= '0;
        end else if (dout_valid) begin
            sreg <= {sreg[30:0], 1'b0};
            cnt  <= cnt - 6'd1;
            pat  <= pat_nxt;
            if (pat_hit) match_cnt <= sat_inc(match_cnt);
        end
    end

endmodule

// File: doc/seq_serial_tx.md
SEQ_SERIAL_TX -- requirements
Module: seq_serial_tx

Interface
REQ-001 The block SHALL have the following ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  request to transmit one frame; sampled only in IDLE.
- data  input  32  frame payload; bit 31 is sent first.
- len  input  6  frame length in bits, 1..32; 0 and 33..63 are treated as 32.
- hold  input  1  stall; while 1, no bit advances.
- dout  output  1  serial bit stream, MSB first.
- dout_valid  output  1  dout carries a frame bit this cycle.
- busy  output  1  frame in progress (SHIFT or DONE).
- done  output  1  one-cycle pulse at end of frame.
- match_cnt  output  4  number of overlapping "11011" occurrences sent in the current or most recent frame.

Function
REQ-002 The block SHALL implement the states IDLE, SHIFT and DONE.
REQ-003 In IDLE, a rising clk edge with start=1 SHALL do all of the following, then go to SHIFT:
- load sreg<=data;
- load bit counter cnt<=effective len;
- clear match_cnt and the internal pattern history.
REQ-004 In IDLE with start=0, the block SHALL stay in IDLE, and sreg and match_cnt SHALL hold.
REQ-005 start SHALL be ignored in SHIFT and DONE; it is never queued.
REQ-006 The outputs SHALL be driven as follows:
- dout = sreg[31] when state is SHIFT, otherwise 0.
- dout_valid = (state==SHIFT) && !hold, combinational.
REQ-007 On each rising edge with dout_valid=1:
- sreg SHALL shift left by one, filling with 0;
- cnt SHALL decrement by 1.
REQ-008 On the valid edge where cnt==1, the state SHALL go to DONE.
REQ-009 The first bit SHALL appear on the cycle after start is accepted; with hold=0 throughout, a frame of length L SHALL occupy exactly L consecutive dout_valid cycles.
REQ-010 While hold=1 in SHIFT:
- sreg, cnt and state SHALL hold;
- dout SHALL keep its current value;
- dout_valid SHALL be 0.
REQ-011 hold SHALL have no effect in IDLE or DONE.
REQ-012 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-013 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-014 A new frame SHALL start no earlier than the cycle after DONE, so the minimum frame-to-frame gap is one idle cycle.
REQ-015 Pattern counting SHALL work as follows:
- an internal Mealy tracker SHALL observe only bits with dout_valid=1;
- it SHALL recognise "11011" with overlap, so after a match the trailing "11" counts as the prefix of the next match;
- match_cnt SHALL increment on the edge that consumes the fifth matching bit.
REQ-016 The tracker history SHALL be cleared at frame start; matches SHALL never span two frames.
REQ-017 match_cnt SHALL hold its final value from DONE until the next accepted start.
REQ-018 match_cnt SHALL saturate at 15; in practice the maximum for a 32-bit frame is 10.
REQ-019 Bits beyond len SHALL never be transmitted; sreg content below bit 32-len is discarded.

Reset
REQ-020 When reset=0, independent of clk, the block SHALL force:
- state=IDLE, sreg=0, cnt=0, tracker=initial, match_cnt=0;
- dout=0, dout_valid=0, busy=0, done=0.
REQ-021 Reset asserted mid-frame SHALL abort the frame immediately; no done pulse SHALL follow.
REQ-022 After reset deassertion, start SHALL be honoured from the first rising clk edge.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- data=32'b01011011011001101101100101101100, len=0, hold=0 -> 32 valid cycles; dout equals data[31] down to data[0]; done pulses once on the cycle after the last bit; match_cnt=5.
- data=32'hDB6D_B6DB ("11011011..."), len=32 -> match_cnt=10; busy high for 33 cycles.
- data=32'hD800_0000, len=5 -> dout 1,1,0,1,1 over 5 valid cycles, then DONE; match_cnt=1; the remaining 27 bits are never driven.
- Frame from the first scenario with hold=1 for 3 cycles after bit 10 and for 1 cycle after bit 20 -> dout_valid low for exactly those 4 cycles; the bit sequence is unchanged; frame length is 36 cycles plus DONE; match_cnt=5.
- start pulsed during SHIFT and during DONE -> ignored; a start in the following IDLE cycle launches a fresh frame with match_cnt cleared to 0.
- reset=0 asynchronously mid-clock during bit 12 -> all outputs 0 before the next edge; no done pulse; a subsequent start transmits a full frame normally.
